// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix keypad scanner with 2-flop row synchroniser, frame debounce and one-hot key strobe.
// Define KEYPAD_REPEAT_EN to re-strobe valid every REPEAT_FRAMES frames while a key stays held.
module keypad_scan #(
  parameter int unsigned SCAN_DIV      = 5000,
  parameter int unsigned DEBOUNCE_CNT  = 4,
  parameter int unsigned REPEAT_FRAMES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [2:0]  key_col,
  output logic [11:0] scan_data,
  output logic        valid,
  output logic        key_held
);
  localparam int unsigned DIV_W = 16;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned REP_W = 8;
  localparam int unsigned KEY_W = 12;

`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCEPT, HELD} state_t;

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div;
  logic             sample_c, frame_end_c;
  logic [KEY_W-1:0] col_bits_c, col_mask_c, frame_c;
  logic [KEY_W-1:0] raw, prev_frame;
  logic [DEB_W-1:0] stable_cnt;
  logic             frame_done;
  logic             stable_c, single_c;
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
  state_t           state, state_n;
  logic [KEY_W-1:0] scan_data_n;
  logic             valid_n, key_held_n;

  // Two-flop synchroniser for the asynchronous row returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  assign sample_c    = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end_c = sample_c && key_col[2];

  // Dwell counter and one-hot column rotation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div     <= '0;
      key_col <= 3'b001;
    end else if (sample_c) begin
      div     <= '0;
      key_col <= {key_col[1:0], key_col[2]};
    end else begin
      div     <= div + DIV_W'(1);
    end
  end

  // Map the driven column's rows onto key-code bit positions
  always_comb begin
    col_bits_c = '0;
    col_mask_c = '0;
    if (key_col[0]) begin
      col_mask_c     = 12'h449;
      col_bits_c[0]  = row_sync[0];
      col_bits_c[3]  = row_sync[1];
      col_bits_c[6]  = row_sync[2];
      col_bits_c[10] = row_sync[3];
    end else if (key_col[1]) begin
      col_mask_c     = 12'h292;
      col_bits_c[1]  = row_sync[0];
      col_bits_c[4]  = row_sync[1];
      col_bits_c[7]  = row_sync[2];
      col_bits_c[9]  = row_sync[3];
    end else if (key_col[2]) begin
      col_mask_c     = 12'h924;
      col_bits_c[2]  = row_sync[0];
      col_bits_c[5]  = row_sync[1];
      col_bits_c[8]  = row_sync[2];
      col_bits_c[11] = row_sync[3];
    end
  end

  assign frame_c = (raw & ~col_mask_c) | col_bits_c;

  // Snapshot assembly and frame-to-frame stability count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw        <= '0;
      prev_frame <= '0;
      stable_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end_c;
      if (sample_c) raw <= frame_c;
      if (frame_end_c) begin
        if (frame_c == prev_frame) begin
          if (stable_cnt != DEB_W'(DEBOUNCE_CNT)) stable_cnt <= stable_cnt + DEB_W'(1);
        end else begin
          stable_cnt <= DEB_W'(1);
          prev_frame <= frame_c;
        end
      end
    end
  end

  assign stable_c = frame_done && (stable_cnt == DEB_W'(DEBOUNCE_CNT));
  assign single_c = (prev_frame != '0) && ((prev_frame & (prev_frame - KEY_W'(1))) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      scan_data <= '0;
      valid     <= 1'b0;
      key_held  <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      state     <= state_n;
      scan_data <= scan_data_n;
      valid     <= valid_n;
      key_held  <= key_held_n;
      rep_cnt   <= rep_cnt_n;
    end
  end

  // Next-state and registered-output decode; decisions only on the cycle after a frame completes
  always_comb begin
    state_n     = state;
    scan_data_n = scan_data;
    valid_n     = 1'b0;
    rep_cnt_n   = '0;
    unique case (state)
      IDLE: begin
        if (stable_c && single_c) begin
          state_n     = ACCEPT;
          scan_data_n = prev_frame;
          valid_n     = 1'b1;
        end
      end
      ACCEPT: state_n = HELD;
      HELD: begin
        rep_cnt_n = rep_cnt;
        if (stable_c && (prev_frame == '0)) begin
          state_n   = IDLE;
          rep_cnt_n = '0;
        end else if (REPEAT_ON && frame_done) begin
          if (prev_frame != scan_data) begin
            rep_cnt_n = '0;
          end else if (rep_cnt == REP_W'(REPEAT_FRAMES - 1)) begin
            rep_cnt_n = '0;
            valid_n   = 1'b1;
          end else begin
            rep_cnt_n = rep_cnt + REP_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    key_held_n = (state_n == HELD);
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_FRAMES=5 (frame = 12 clks).
`timescale 1ns/1ps
module tb_keypad_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic [11:0] scan_data;
  logic        valid;
  logic        key_held;
  logic [11:0] keys;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int consec_err = 0;
  logic prev_v = 1'b0;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_EXP = 4;
`else
  localparam int REP_EXP = 1;
`endif

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_FRAMES(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_row   (key_row),
    .key_col   (key_col),
    .scan_data (scan_data),
    .valid     (valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key connects its column drive to its row return
  always_comb begin
    key_row    = 4'b0000;
    key_row[0] = |(keys[2:0] & key_col);
    key_row[1] = |(keys[5:3] & key_col);
    key_row[2] = |(keys[8:6] & key_col);
    key_row[3] = |({keys[11], keys[9], keys[10]} & key_col);
  end

  always @(posedge clk) begin
    if (valid) begin
      vcount <= vcount + 1;
      if (prev_v) consec_err <= consec_err + 1;
    end
    prev_v <= valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    logic [2:0] last;
    bit found;
    last  = key_col;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (key_col == 3'b001 && last == 3'b100) found = 1'b1;
      last = key_col;
    end
    total++;
    if (!found) begin bad++; $display("FAIL align: key_col never wrapped 100->001"); end
  endtask

  task automatic test_reset();
    logic [2:0] exp_col;
    rst  = 1'b0;
    keys = '0;
    run(3);
    total++; if (key_col !== 3'b001) begin bad++; $display("FAIL reset_col: got %b want 001", key_col); end
    total++; if (scan_data !== 12'h000) begin bad++; $display("FAIL reset_data: got %h want 000", scan_data); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_col = 3'b001 << ((i / 4) % 3);
      total++;
      if (key_col !== exp_col) begin bad++; $display("FAIL scan_col[%0d]: got %b want %b", i, key_col, exp_col); end
      run(1);
    end
    run(24);
    total++; if (vcount !== 0) begin bad++; $display("FAIL idle_valid: got %0d strobes want 0", vcount); end
    total++; if (scan_data !== 12'h000) begin bad++; $display("FAIL idle_data: got %h want 000", scan_data); end
  endtask

  task automatic test_key_press(input logic [11:0] code, input string tag);
    int base;
    base = vcount;
    keys = code;
    run(60);
    total++; if (vcount - base !== 1) begin bad++; $display("FAIL %s_count: got %0d strobes want 1", tag, vcount - base); end
    total++; if (scan_data !== code) begin bad++; $display("FAIL %s_data: got %h want %h", tag, scan_data, code); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL %s_held: got %b want 1", tag, key_held); end
    keys = '0;
    run(24);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL %s_held_early: got %b want 1", tag, key_held); end
    run(48);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL %s_release: got %b want 0", tag, key_held); end
    total++; if (vcount - base !== 1) begin bad++; $display("FAIL %s_post_count: got %0d want 1", tag, vcount - base); end
  endtask

  task automatic test_single_key();
    test_key_press(12'h010, "key5");
  endtask

  task automatic test_special_keys();
    test_key_press(12'h200, "key0");
    test_key_press(12'h400, "keystar");
    test_key_press(12'h800, "keyhash");
  endtask

  task automatic test_bounce();
    int base;
    align();
    run(3);
    base = vcount;
    keys = 12'h080;
    for (int i = 0; i < 48; i++) begin
      if (i > 0 && (i % 7) == 0) keys[7] = ~keys[7];
      run(1);
    end
    keys = 12'h080;
    total++; if (vcount !== base) begin bad++; $display("FAIL bounce_quiet: got %0d strobes want 0", vcount - base); end
    run(33);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL bounce_early: got valid %b want 0", valid); end
    run(1);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL bounce_latency: got valid %b want 1", valid); end
    total++; if (scan_data !== 12'h080) begin bad++; $display("FAIL bounce_data: got %h want 080", scan_data); end
    run(1);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL bounce_pulse: got valid %b want 0", valid); end
    keys = '0;
    run(72);
  endtask

  task automatic test_ghost();
    int base;
    base = vcount;
    keys = 12'h003;
    run(72);
    total++; if (vcount !== base) begin bad++; $display("FAIL ghost_count: got %0d strobes want 0", vcount - base); end
    total++; if (scan_data !== 12'h080) begin bad++; $display("FAIL ghost_data: got %h want 080", scan_data); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL ghost_held: got %b want 0", key_held); end
    keys = '0;
    run(48);
  endtask

  task automatic test_reset_mid_held();
    int base;
    keys = 12'h010;
    run(60);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL mid_held_pre: got %b want 1", key_held); end
    rst = 1'b0;
    #1;
    total++; if (scan_data !== 12'h000) begin bad++; $display("FAIL mid_rst_data: got %h want 000", scan_data); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL mid_rst_held: got %b want 0", key_held); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
    total++; if (key_col !== 3'b001) begin bad++; $display("FAIL mid_rst_col: got %b want 001", key_col); end
    run(1);
    rst  = 1'b1;
    base = vcount;
    run(24);
    total++; if (vcount !== base) begin bad++; $display("FAIL mid_rst_nostrobe: got %0d want 0", vcount - base); end
    run(12);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_rst_early: got valid %b want 0", valid); end
    run(1);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL mid_rst_latency: got valid %b want 1", valid); end
    total++; if (scan_data !== 12'h010) begin bad++; $display("FAIL mid_rst_data2: got %h want 010", scan_data); end
    keys = '0;
    run(72);
  endtask

  task automatic test_repeat();
    int base;
    align();
    base = vcount;
    keys = 12'h004;
    run(36);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL hold3_early: got valid %b want 0", valid); end
    run(1);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL hold3_latency: got valid %b want 1", valid); end
    run(203);
    keys = '0;
    run(24);
    total++; if (vcount - base !== REP_EXP) begin bad++; $display("FAIL hold3_count: got %0d strobes want %0d", vcount - base, REP_EXP); end
    total++; if (scan_data !== 12'h004) begin bad++; $display("FAIL hold3_data: got %h want 004", scan_data); end
    run(48);
  endtask

  task automatic test_back_to_back();
    total++; if (consec_err !== 0) begin bad++; $display("FAIL back_to_back: got %0d consecutive strobes want 0", consec_err); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_special_keys();
    test_bounce();
    test_ghost();
    test_reset_mid_held();
    test_repeat();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
